// File: rtl/pm_fetch_sequencer_if.sv
// Fetch-path bundle: PC-side request, SROM address/data, and decoder hand-off.
// The slave modport is the sequencer's view; master is the surrounding datapath.
interface pm_fetch_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              flush;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;

  modport master (
    output fetch_valid, fetch_addr, flush, pm_data, instr_ready,
    input  fetch_ready, pm_addr, instr_valid, instr_out
  );

  modport slave (
    input  fetch_valid, fetch_addr, flush, pm_data, instr_ready,
    output fetch_ready, pm_addr, instr_valid, instr_out
  );
endinterface

// File: rtl/pm_fetch_sequencer.sv
// Multicycle program-memory fetch controller: launches an SROM read, waits for the
// slow delay chain to settle, then hands the captured instruction to the decoder.
module pm_fetch_sequencer #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pm_fetch_sequencer_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  logic [1:0]        state;
  logic [7:0]        settle_cnt;
  logic [ADDR_W-1:0] pm_addr_q;
  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q;
  logic              fetch_ready_c;
  logic              accept;

  // A new request may enter while idle, or in the same cycle the decoder drains DONE.
  always_comb begin
    fetch_ready_c = 1'b0;
    if (reset_n && !bus.flush) begin
      fetch_ready_c = (state == IDLE) || ((state == DONE) && bus.instr_ready);
    end
  end

  assign accept          = bus.fetch_valid && fetch_ready_c;
  assign bus.fetch_ready = fetch_ready_c;
  assign bus.pm_addr     = pm_addr_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign busy            = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      settle_cnt    <= 8'd0;
      pm_addr_q     <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_count   <= '0;
    end else if (bus.flush) begin
      // Flush aborts everything but leaves the address and last instruction in place.
      state         <= IDLE;
      instr_valid_q <= 1'b0;
      settle_cnt    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pm_addr_q <= bus.fetch_addr;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          settle_cnt <= SETTLE_INIT;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == 8'd0) begin
            instr_q       <= bus.pm_data;
            instr_valid_q <= 1'b1;
            state         <= DONE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        DONE: begin
          if (bus.instr_ready) begin
            fetch_count   <= fetch_count + CNT_W'(1);
            instr_valid_q <= 1'b0;
            if (accept) begin
              pm_addr_q <= bus.fetch_addr;
              state     <= LAUNCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_fetch_sequencer.sv
// Bench for pm_fetch_sequencer: directed scenarios plus a randomized run against a
// timing-arithmetic model; a second instance covers SETTLE_CYCLES=1 and a 4-bit counter.
module tb_pm_fetch_sequencer;

  localparam int S_A = 3;
  localparam int S_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  int          checks = 0;
  int          errors = 0;

  pm_fetch_sequencer_if #(.ADDR_W(8), .DATA_W(8)) ifa ();
  pm_fetch_sequencer_if #(.ADDR_W(8), .DATA_W(8)) ifb ();

  // SROM plus delay chain: the settled word is the address scrambled with 0xA5.
  assign ifa.pm_data = ifa.pm_addr ^ 8'hA5;
  assign ifb.pm_data = ifb.pm_addr ^ 8'hA5;

  pm_fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .SETTLE_CYCLES(S_A), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(rst_a), .bus(ifa.slave), .busy(busy_a), .fetch_count(cnt_a)
  );

  pm_fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .SETTLE_CYCLES(S_B), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(rst_b), .bus(ifb.slave), .busy(busy_b), .fetch_count(cnt_b)
  );

  // Reference model: a fetch accepted in cycle t is valid from cycle t+S+2 until drained.
  int          m_cyc, m_acc;
  bit          m_busy;
  logic [7:0]  m_pm, m_out;
  logic [15:0] m_cnt;
  bit          e_valid, e_ready;

  task automatic model_reset();
    m_cyc = 0; m_acc = 0; m_busy = 0; m_pm = 8'h00; m_out = 8'h00; m_cnt = 16'h0000;
  endtask

  function automatic void model_eval();
    e_valid = m_busy && ((m_cyc - m_acc) >= S_A + 2);
    e_ready = rst_a && !ifa.flush && (!m_busy || (e_valid && ifa.instr_ready));
  endfunction

  task automatic model_commit();
    model_eval();
    if (ifa.flush) begin
      m_busy = 0;
    end else begin
      if (m_busy && (m_cyc - m_acc) == S_A + 1) m_out = m_pm ^ 8'hA5;
      if (e_valid && ifa.instr_ready) begin
        m_cnt  = m_cnt + 16'd1;
        m_busy = 0;
      end
      if (ifa.fetch_valid && e_ready) begin
        m_busy = 1; m_acc = m_cyc; m_pm = ifa.fetch_addr;
      end
    end
    m_cyc++;
  endtask

  task automatic tick_a();
    @(posedge clk);
    if (!rst_a) model_reset(); else model_commit();
    #1;
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    ifa.fetch_valid = 1'b0; ifa.fetch_addr = 8'h00; ifa.flush = 1'b0; ifa.instr_ready = 1'b0;
    tick_a(); tick_a();
    rst_a = 1'b1;
  endtask

  task automatic reset_b();
    rst_b = 1'b0;
    ifb.fetch_valid = 1'b0; ifb.fetch_addr = 8'h00; ifb.flush = 1'b0; ifb.instr_ready = 1'b0;
    tick_b(); tick_b();
    rst_b = 1'b1;
  endtask

  // Called at the sampling point of the accept cycle; returns cycles until instr_valid, or -1.
  task automatic wait_valid_a(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick_a();
      if (i == 1) ifa.fetch_valid = 1'b0;
      @(negedge clk);
      if (ifa.instr_valid) begin n = i; break; end
    end
  endtask

  task automatic wait_valid_b(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick_b();
      if (i == 1) ifb.fetch_valid = 1'b0;
      @(negedge clk);
      if (ifb.instr_valid) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    ifa.fetch_valid = 1'b1; ifa.fetch_addr = 8'h77; ifa.flush = 1'b0; ifa.instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (ifa.fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_ready got %0h expected 0", ifa.fetch_ready); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0h expected 0", busy_a); end
    checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_valid got %0h expected 0", ifa.instr_valid); end
    checks++; if (ifa.pm_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_pm_addr got %0h expected 0", ifa.pm_addr); end
    checks++; if (ifa.instr_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_instr_out got %0h expected 0", ifa.instr_out); end
    checks++; if (cnt_a !== 16'h0000) begin errors++; $display("[TB] FAIL reset_fetch_count got %0h expected 0", cnt_a); end
    tick_a(); tick_a();
    ifa.fetch_valid = 1'b0;
    rst_a = 1'b1;
    @(negedge clk);
    checks++; if (ifa.fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_fetch_ready got %0h expected 1", ifa.fetch_ready); end
  endtask

  task automatic test_single_fetch();
    int n;
    ifa.instr_ready = 1'b1; ifa.fetch_addr = 8'h12; ifa.fetch_valid = 1'b1;
    wait_valid_a(12, n);
    checks++; if (n !== S_A + 2) begin errors++; $display("[TB] FAIL single_latency got %0d expected %0d", n, S_A + 2); end
    checks++; if (ifa.pm_addr !== 8'h12) begin errors++; $display("[TB] FAIL single_pm_addr got %0h expected 12", ifa.pm_addr); end
    checks++; if (ifa.instr_out !== 8'hB7) begin errors++; $display("[TB] FAIL single_instr_out got %0h expected b7", ifa.instr_out); end
    tick_a();
    @(negedge clk);
    checks++; if (cnt_a !== 16'd1) begin errors++; $display("[TB] FAIL single_count got %0d expected 1", cnt_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL single_busy got %0h expected 0", busy_a); end
  endtask

  task automatic test_back_pressure();
    int n;
    ifa.instr_ready = 1'b0; ifa.fetch_addr = 8'h12; ifa.fetch_valid = 1'b1;
    wait_valid_a(12, n);
    checks++; if (n !== S_A + 2) begin errors++; $display("[TB] FAIL bp_latency got %0d expected %0d", n, S_A + 2); end
    // Requester holds a request that must be ignored while the decoder stalls.
    ifa.fetch_valid = 1'b1; ifa.fetch_addr = 8'h13;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin tick_a(); @(negedge clk); end
      checks++;
      if ({ifa.instr_valid, ifa.instr_out, ifa.fetch_ready, ifa.pm_addr} !== {1'b1, 8'hB7, 1'b0, 8'h12}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d got valid=%0h out=%0h ready=%0h pm=%0h expected 1 b7 0 12",
                 k, ifa.instr_valid, ifa.instr_out, ifa.fetch_ready, ifa.pm_addr);
      end
    end
    ifa.instr_ready = 1'b1;
    #1;
    checks++; if (ifa.fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_release got %0h expected 1", ifa.fetch_ready); end
    wait_valid_a(12, n);
    checks++; if (n !== S_A + 2) begin errors++; $display("[TB] FAIL b2b_latency got %0d expected %0d", n, S_A + 2); end
    checks++; if (ifa.instr_out !== 8'hB6) begin errors++; $display("[TB] FAIL b2b_instr_out got %0h expected b6", ifa.instr_out); end
    checks++; if (ifa.pm_addr !== 8'h13) begin errors++; $display("[TB] FAIL b2b_pm_addr got %0h expected 13", ifa.pm_addr); end
    checks++; if (cnt_a !== 16'd2) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 2", cnt_a); end
    tick_a();
    @(negedge clk);
  endtask

  task automatic test_flush_settle();
    int n;
    ifa.instr_ready = 1'b1; ifa.fetch_addr = 8'h20; ifa.fetch_valid = 1'b1;
    tick_a();
    ifa.fetch_valid = 1'b0;
    tick_a(); tick_a();
    ifa.flush = 1'b1;
    @(negedge clk);
    checks++; if ({ifa.fetch_ready, busy_a} !== 2'b01) begin errors++; $display("[TB] FAIL flush_cycle got ready=%0h busy=%0h expected 0 1", ifa.fetch_ready, busy_a); end
    tick_a();
    ifa.flush = 1'b0;
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle got %0h expected 0", busy_a); end
    checks++; if (ifa.pm_addr !== 8'h20) begin errors++; $display("[TB] FAIL flush_pm_addr got %0h expected 20", ifa.pm_addr); end
    checks++; if (ifa.instr_out !== 8'hB6) begin errors++; $display("[TB] FAIL flush_instr_out got %0h expected b6", ifa.instr_out); end
    checks++; if (cnt_a !== 16'd3) begin errors++; $display("[TB] FAIL flush_count got %0d expected 3", cnt_a); end
    for (int k = 0; k < 6; k++) begin
      tick_a(); @(negedge clk);
      checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_valid%0d got %0h expected 0", k, ifa.instr_valid); end
    end
    ifa.fetch_addr = 8'h30; ifa.fetch_valid = 1'b1;
    wait_valid_a(12, n);
    checks++; if (n !== S_A + 2) begin errors++; $display("[TB] FAIL post_flush_latency got %0d expected %0d", n, S_A + 2); end
    checks++; if (ifa.instr_out !== 8'h95) begin errors++; $display("[TB] FAIL post_flush_out got %0h expected 95", ifa.instr_out); end
    tick_a();
    @(negedge clk);
  endtask

  task automatic test_flush_done();
    int n;
    ifa.instr_ready = 1'b0; ifa.fetch_addr = 8'h44; ifa.fetch_valid = 1'b1;
    wait_valid_a(12, n);
    checks++; if (n !== S_A + 2) begin errors++; $display("[TB] FAIL fdone_latency got %0d expected %0d", n, S_A + 2); end
    ifa.flush = 1'b1; ifa.instr_ready = 1'b1; ifa.fetch_valid = 1'b1;
    #1;
    checks++; if (ifa.fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL fdone_ready got %0h expected 0", ifa.fetch_ready); end
    tick_a();
    ifa.flush = 1'b0; ifa.instr_ready = 1'b0; ifa.fetch_valid = 1'b0;
    @(negedge clk);
    checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL fdone_valid got %0h expected 0", ifa.instr_valid); end
    checks++; if (cnt_a !== 16'd4) begin errors++; $display("[TB] FAIL fdone_count got %0d expected 4", cnt_a); end
    checks++; if (ifa.instr_out !== 8'hE1) begin errors++; $display("[TB] FAIL fdone_out got %0h expected e1", ifa.instr_out); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL fdone_busy got %0h expected 0", busy_a); end
  endtask

  task automatic test_async_reset();
    int n;
    ifa.instr_ready = 1'b1; ifa.fetch_addr = 8'h55; ifa.fetch_valid = 1'b1;
    tick_a();
    ifa.fetch_valid = 1'b0;
    tick_a();
    #3 rst_a = 1'b0;
    #1;
    checks++;
    if ({ifa.pm_addr, ifa.instr_out, ifa.instr_valid, busy_a, cnt_a, ifa.fetch_ready} !== 35'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got pm=%0h out=%0h valid=%0h busy=%0h cnt=%0h ready=%0h expected all 0",
               ifa.pm_addr, ifa.instr_out, ifa.instr_valid, busy_a, cnt_a, ifa.fetch_ready);
    end
    tick_a();
    rst_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick_a(); @(negedge clk);
      checks++; if ({ifa.instr_valid, busy_a} !== 2'b00) begin errors++; $display("[TB] FAIL post_reset_quiet%0d got valid=%0h busy=%0h expected 0 0", k, ifa.instr_valid, busy_a); end
    end
    ifa.fetch_addr = 8'h5A; ifa.fetch_valid = 1'b1;
    wait_valid_a(12, n);
    checks++; if (n !== S_A + 2) begin errors++; $display("[TB] FAIL post_reset_latency got %0d expected %0d", n, S_A + 2); end
    checks++; if (ifa.instr_out !== 8'hFF) begin errors++; $display("[TB] FAIL post_reset_out got %0h expected ff", ifa.instr_out); end
    tick_a();
  endtask

  task automatic test_random();
    reset_a();
    for (int c = 0; c < 400; c++) begin
      ifa.fetch_valid = ($urandom_range(0, 1) == 1);
      ifa.fetch_addr  = 8'($urandom);
      ifa.instr_ready = ($urandom_range(0, 3) != 0);
      ifa.flush       = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      model_eval();
      checks++; if (ifa.fetch_ready !== e_ready) begin errors++; $display("[TB] FAIL rnd_ready c%0d got %0h expected %0h", c, ifa.fetch_ready, e_ready); end
      checks++; if (ifa.instr_valid !== e_valid) begin errors++; $display("[TB] FAIL rnd_valid c%0d got %0h expected %0h", c, ifa.instr_valid, e_valid); end
      checks++; if (busy_a !== m_busy) begin errors++; $display("[TB] FAIL rnd_busy c%0d got %0h expected %0h", c, busy_a, m_busy); end
      checks++; if (ifa.pm_addr !== m_pm) begin errors++; $display("[TB] FAIL rnd_pm_addr c%0d got %0h expected %0h", c, ifa.pm_addr, m_pm); end
      checks++; if (ifa.instr_out !== m_out) begin errors++; $display("[TB] FAIL rnd_instr_out c%0d got %0h expected %0h", c, ifa.instr_out, m_out); end
      checks++; if (cnt_a !== m_cnt) begin errors++; $display("[TB] FAIL rnd_count c%0d got %0h expected %0h", c, cnt_a, m_cnt); end
      tick_a();
    end
    ifa.fetch_valid = 1'b0; ifa.flush = 1'b0; ifa.instr_ready = 1'b1;
    tick_a();
  endtask

  task automatic test_settle_one();
    int n;
    reset_b();
    ifb.instr_ready = 1'b1; ifb.fetch_addr = 8'h12; ifb.fetch_valid = 1'b1;
    @(negedge clk);
    checks++; if (ifb.fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL s1_ready got %0h expected 1", ifb.fetch_ready); end
    wait_valid_b(8, n);
    checks++; if (n !== S_B + 2) begin errors++; $display("[TB] FAIL s1_latency got %0d expected %0d", n, S_B + 2); end
    checks++; if (ifb.instr_out !== 8'hB7) begin errors++; $display("[TB] FAIL s1_instr_out got %0h expected b7", ifb.instr_out); end
    tick_b();
    @(negedge clk);
    checks++; if ({cnt_b, busy_b} !== {4'd1, 1'b0}) begin errors++; $display("[TB] FAIL s1_done got cnt=%0d busy=%0h expected 1 0", cnt_b, busy_b); end
  endtask

  task automatic test_count_wrap();
    int n;
    logic [7:0] a;
    reset_b();
    ifb.instr_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 17; k++) begin
      a = 8'($urandom);
      ifb.fetch_addr = a; ifb.fetch_valid = 1'b1;
      wait_valid_b(8, n);
      checks++;
      if ({n[7:0], ifb.instr_out} !== {8'(S_B + 2), a ^ 8'hA5}) begin
        errors++;
        $display("[TB] FAIL wrap_fetch%0d got lat=%0d out=%0h expected %0d %0h", k, n, ifb.instr_out, S_B + 2, a ^ 8'hA5);
      end
      tick_b();
      @(negedge clk);
      if (k == 15) begin
        checks++; if (cnt_b !== 4'd0) begin errors++; $display("[TB] FAIL wrap_at16 got %0d expected 0", cnt_b); end
      end
    end
    checks++; if (cnt_b !== 4'd1) begin errors++; $display("[TB] FAIL wrap_final got %0d expected 1", cnt_b); end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.fetch_valid = 1'b0; ifa.fetch_addr = 8'h00; ifa.flush = 1'b0; ifa.instr_ready = 1'b0;
    ifb.fetch_valid = 1'b0; ifb.fetch_addr = 8'h00; ifb.flush = 1'b0; ifb.instr_ready = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_single_fetch();
    test_back_pressure();
    test_flush_settle();
    test_flush_done();
    test_async_reset();
    test_random();
    test_settle_one();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
